// File: rtl/multi_block_layer_scheduler.sv
// Round-robin layer fetch across NUM_BLOCKS ranges, CIM/NPU
// assignment against a per-round CIM budget, ordered dispatch.
module multi_block_layer_scheduler #(
    parameter int NUM_BLOCKS = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_W-1:0]            npu_capability_i,
    input  logic [DATA_W-1:0]            cim_capability_i,
    input  logic [NUM_BLOCKS*ADDR_W-1:0] block_start_i,
    input  logic [NUM_BLOCKS*LEN_W-1:0]  block_length_i,
    input  logic                         schedule_valid_i,
    output logic                         schedule_ready_o,
    output logic                         cfg_req_o,
    output logic [ADDR_W-1:0]            cfg_addr_o,
    input  logic                         cfg_rvalid_i,
    input  logic [DATA_W-1:0]            cfg_rdata_i,
    output logic                         dispatch_valid_o,
    input  logic                         dispatch_ready_i,
    output logic [BW-1:0]                dispatch_block_o,
    output logic [ADDR_W-1:0]            dispatch_addr_o,
    output logic [DATA_W-1:0]            dispatch_cost_o,
    output logic                         dispatch_target_o,
    output logic                         dispatch_err_o,
    output logic                         dispatch_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPARE, DISPATCH} state_t;

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     rblk_q;
    logic [BW-1:0]     last_q;
    logic [DATA_W-1:0] npu_cap_q;
    logic [DATA_W-1:0] cim_cap_q;
    logic [DATA_W-1:0] rem_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic              valid_q;

    logic [ADDR_W-1:0] start_q [NUM_BLOCKS];
    logic [LEN_W-1:0]  len_q   [NUM_BLOCKS];
    logic [LEN_W-1:0]  ptr_q   [NUM_BLOCKS];

    logic [BW-1:0]     buf_blk  [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr [BUF_DEPTH];
    logic [DATA_W-1:0] buf_cost [BUF_DEPTH];
    logic              buf_tgt  [BUF_DEPTH];
    logic              buf_err  [BUF_DEPTH];

    logic [NUM_BLOCKS-1:0] rem_vec;
    logic                  any_rem;
    logic                  found;
    logic [BW-1:0]         sel;
    logic                  lens_zero;
    logic                  idx_last;
    logic [DATA_W-1:0]     cur_cost;

    // Pick the lowest pending block above the last served one, else wrap.
    always_comb begin
        rem_vec = '0;
        for (int i = 0; i < NUM_BLOCKS; i++)
            rem_vec[i] = ptr_q[i] < len_q[i];
        any_rem = |rem_vec;
        sel     = '0;
        found   = 1'b0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (rem_vec[i] && BW'(i) > last_q) begin
                sel   = BW'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = NUM_BLOCKS - 1; i >= 0; i--)
                if (rem_vec[i]) sel = BW'(i);
        end
    end

    always_comb begin
        lens_zero = 1'b1;
        for (int i = 0; i < NUM_BLOCKS; i++)
            if (block_length_i[i*LEN_W +: LEN_W] != '0) lens_zero = 1'b0;
    end

    assign idx_last = (CW'(idx_q) == cnt_q - CW'(1));
    assign cur_cost = buf_cost[idx_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            rblk_q    <= '0;
            last_q    <= '0;
            npu_cap_q <= '0;
            cim_cap_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                start_q[i] <= '0;
                len_q[i]   <= '0;
                ptr_q[i]   <= '0;
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_blk[i]  <= '0;
                buf_addr[i] <= '0;
                buf_cost[i] <= '0;
                buf_tgt[i]  <= 1'b0;
                buf_err[i]  <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (schedule_valid_i && ready_q) begin
                        npu_cap_q <= npu_capability_i;
                        cim_cap_q <= cim_capability_i;
                        last_q    <= BW'(NUM_BLOCKS - 1);
                        cnt_q     <= '0;
                        for (int i = 0; i < NUM_BLOCKS; i++) begin
                            start_q[i] <= block_start_i[i*ADDR_W +: ADDR_W];
                            len_q[i]   <= block_length_i[i*LEN_W +: LEN_W];
                            ptr_q[i]   <= '0;
                        end
                        if (lens_zero) begin
                            done_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b0;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (req_q) begin
                        if (cfg_rvalid_i) begin
                            req_q                   <= 1'b0;
                            buf_blk[cnt_q[IW-1:0]]  <= rblk_q;
                            buf_addr[cnt_q[IW-1:0]] <= addr_q;
                            buf_cost[cnt_q[IW-1:0]] <= cfg_rdata_i;
                            ptr_q[rblk_q] <= ptr_q[rblk_q] + LEN_W'(1);
                            last_q        <= rblk_q;
                            cnt_q         <= cnt_q + CW'(1);
                        end
                    end else if (cnt_q == CW'(BUF_DEPTH) || !any_rem) begin
                        state_q <= COMPARE;
                        idx_q   <= '0;
                        rem_q   <= cim_cap_q;
                    end else begin
                        req_q  <= 1'b1;
                        addr_q <= start_q[sel] + ADDR_W'(ptr_q[sel]);
                        rblk_q <= sel;
                    end
                end
                COMPARE: begin
                    if (cur_cost <= rem_q) begin
                        buf_tgt[idx_q] <= 1'b1;
                        buf_err[idx_q] <= 1'b0;
                        rem_q          <= rem_q - cur_cost;
                    end else begin
                        buf_tgt[idx_q] <= 1'b0;
                        buf_err[idx_q] <= cur_cost > npu_cap_q;
                    end
                    if (idx_last) begin
                        state_q <= DISPATCH;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DISPATCH: begin
                    if (valid_q && dispatch_ready_i) begin
                        if (idx_last) begin
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            if (any_rem) begin
                                state_q <= LOAD;
                            end else begin
                                state_q <= IDLE;
                                ready_q <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign schedule_ready_o  = ready_q;
    assign cfg_req_o         = req_q;
    assign cfg_addr_o        = addr_q;
    assign dispatch_valid_o  = valid_q;
    assign dispatch_block_o  = valid_q ? buf_blk[idx_q]  : '0;
    assign dispatch_addr_o   = valid_q ? buf_addr[idx_q] : '0;
    assign dispatch_cost_o   = valid_q ? buf_cost[idx_q] : '0;
    assign dispatch_target_o = valid_q & buf_tgt[idx_q];
    assign dispatch_err_o    = valid_q & buf_err[idx_q];
    assign dispatch_last_o   = valid_q & idx_last & ~any_rem;
    assign busy_o            = state_q != IDLE;
    assign done_o            = done_q;

endmodule

// File: tb/tb_multi_block_layer_scheduler.sv
// Directed bench for multi_block_layer_scheduler with a
// config-memory responder (cost = address low byte unless overridden).
module tb_multi_block_layer_scheduler;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] npu_capability_i;
    logic [31:0] cim_capability_i;
    logic [63:0] block_start_i;
    logic [15:0] block_length_i;
    logic        schedule_valid_i;
    logic        schedule_ready_o;
    logic        cfg_req_o;
    logic [31:0] cfg_addr_o;
    logic        cfg_rvalid_i;
    logic [31:0] cfg_rdata_i;
    logic        dispatch_valid_o;
    logic        dispatch_ready_i;
    logic [0:0]  dispatch_block_o;
    logic [31:0] dispatch_addr_o;
    logic [31:0] dispatch_cost_o;
    logic        dispatch_target_o;
    logic        dispatch_err_o;
    logic        dispatch_last_o;
    logic        busy_o;
    logic        done_o;

    multi_block_layer_scheduler dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .npu_capability_i (npu_capability_i),
        .cim_capability_i (cim_capability_i),
        .block_start_i    (block_start_i),
        .block_length_i   (block_length_i),
        .schedule_valid_i (schedule_valid_i),
        .schedule_ready_o (schedule_ready_o),
        .cfg_req_o        (cfg_req_o),
        .cfg_addr_o       (cfg_addr_o),
        .cfg_rvalid_i     (cfg_rvalid_i),
        .cfg_rdata_i      (cfg_rdata_i),
        .dispatch_valid_o (dispatch_valid_o),
        .dispatch_ready_i (dispatch_ready_i),
        .dispatch_block_o (dispatch_block_o),
        .dispatch_addr_o  (dispatch_addr_o),
        .dispatch_cost_o  (dispatch_cost_o),
        .dispatch_target_o(dispatch_target_o),
        .dispatch_err_o   (dispatch_err_o),
        .dispatch_last_o  (dispatch_last_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int          rd_delay   = 0;
    logic        ovr_en     = 1'b0;
    logic [31:0] ovr_cost   = '0;
    int          spur_req   = 0;
    int          unstable   = 0;
    int          drops      = 0;
    int          req_cnt    = 0;
    int          done_cnt   = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] cost_of(input logic [31:0] a);
        return ovr_en ? ovr_cost : {24'h0, a[7:0]};
    endfunction

    // Config-memory responder with programmable latency.
    initial begin
        int          wcnt;
        int          spur_done;
        logic [31:0] hold_addr;
        wcnt = 0;
        spur_done = 0;
        hold_addr = '0;
        cfg_rvalid_i = 1'b0;
        cfg_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            if (cfg_rvalid_i) begin
                cfg_rvalid_i = 1'b0;
            end else if (spur_req != spur_done) begin
                spur_done    = spur_req;
                cfg_rvalid_i = 1'b1;
                cfg_rdata_i  = 32'hdead;
            end else if (rst_i || !cfg_req_o) begin
                if (wcnt != 0 && !rst_i) drops++;
                wcnt = 0;
            end else begin
                if (wcnt == 0) hold_addr = cfg_addr_o;
                else if (cfg_addr_o != hold_addr) unstable++;
                if (wcnt == rd_delay) begin
                    cfg_rvalid_i = 1'b1;
                    cfg_rdata_i  = cost_of(cfg_addr_o);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (cfg_req_o) req_cnt++;
            if (done_o) done_cnt++;
        end
    end

    task automatic start_sched(input logic [63:0] st, input logic [15:0] ln,
                               input logic [31:0] cim, input logic [31:0] npu);
        int t;
        t = 0;
        while (!schedule_ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        chk("sched_ready", 64'(schedule_ready_o), 64'd1);
        block_start_i    = st;
        block_length_i   = ln;
        cim_capability_i = cim;
        npu_capability_i = npu;
        schedule_valid_i = 1'b1;
        @(negedge clk_i);
        schedule_valid_i = 1'b0;
    endtask

    task automatic take(input string tag, input logic blk,
                        input logic [31:0] addr, input logic [31:0] cost,
                        input logic tgt, input logic err, input logic last,
                        input int stall);
        int t;
        int bad;
        logic [67:0] snap;
        t = 0;
        bad = 0;
        while (!dispatch_valid_o && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_vld"}, 64'(dispatch_valid_o), 64'd1);
        snap = {dispatch_block_o, dispatch_addr_o, dispatch_cost_o,
                dispatch_target_o, dispatch_err_o, dispatch_last_o};
        for (int k = 0; k < stall; k++) begin
            @(negedge clk_i);
            if (!dispatch_valid_o ||
                snap != {dispatch_block_o, dispatch_addr_o, dispatch_cost_o,
                         dispatch_target_o, dispatch_err_o, dispatch_last_o})
                bad++;
        end
        if (stall > 0) chk({tag, "_hold"}, 64'(bad), 64'd0);
        chk({tag, "_addr"}, 64'(dispatch_addr_o), 64'(addr));
        chk({tag, "_cost"}, 64'(dispatch_cost_o), 64'(cost));
        chk({tag, "_flags"},
            64'({dispatch_block_o, dispatch_target_o, dispatch_err_o,
                 dispatch_last_o}),
            64'({blk, tgt, err, last}));
        dispatch_ready_i = 1'b1;
        @(negedge clk_i);
        dispatch_ready_i = 1'b0;
    endtask

    function automatic logic any_out();
        return schedule_ready_o | cfg_req_o | (|cfg_addr_o) |
               dispatch_valid_o | (|dispatch_block_o) |
               (|dispatch_addr_o) | (|dispatch_cost_o) |
               dispatch_target_o | dispatch_err_o | dispatch_last_o |
               busy_o | done_o;
    endfunction

    initial begin
        int r0;
        int d0;
        rst_i            = 1'b1;
        npu_capability_i = '0;
        cim_capability_i = '0;
        block_start_i    = '0;
        block_length_i   = '0;
        schedule_valid_i = 1'b0;
        dispatch_ready_i = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("reset_outs", 64'(any_out()), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("idle_ready_busy", 64'({schedule_ready_o, busy_o}), 64'b10);

        // Spurious read data while idle must not start anything.
        spur_req++;
        repeat (4) @(negedge clk_i);
        chk("spurious_idle",
            64'({cfg_req_o, busy_o, dispatch_valid_o, done_o}), 64'd0);

        // Two blocks, slow memory, stall on second entry.
        rd_delay = 7;
        d0 = done_cnt;
        start_sched({32'h40, 32'h10}, {8'd2, 8'd3}, 32'h60, 32'hFF);
        chk("t1_busy", 64'(busy_o), 64'd1);
        take("t1_e0", 1'b0, 32'h10, 32'h10, 1'b1, 1'b0, 1'b0, 0);
        take("t1_e1", 1'b1, 32'h40, 32'h40, 1'b1, 1'b0, 1'b0, 5);
        take("t1_e2", 1'b0, 32'h11, 32'h11, 1'b0, 1'b0, 1'b0, 0);
        take("t1_e3", 1'b1, 32'h41, 32'h41, 1'b0, 1'b0, 1'b0, 0);
        take("t1_e4", 1'b0, 32'h12, 32'h12, 1'b1, 1'b0, 1'b1, 0);
        chk("t1_done", 64'(done_o), 64'd1);
        repeat (3) @(negedge clk_i);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t1_idle", 64'({busy_o, dispatch_valid_o, schedule_ready_o}),
            64'b001);
        chk("t1_req_stable", 64'(unstable), 64'd0);
        chk("t1_req_held", 64'(drops), 64'd0);
        rd_delay = 0;

        // All lengths zero.
        r0 = req_cnt;
        d0 = done_cnt;
        start_sched({32'h40, 32'h10}, 16'h0000, 32'h60, 32'hFF);
        chk("t2_done", 64'({done_o, busy_o, schedule_ready_o}), 64'b101);
        @(negedge clk_i);
        chk("t2_done_drop", 64'(done_o), 64'd0);
        repeat (3) @(negedge clk_i);
        chk("t2_no_reads", 64'(req_cnt - r0), 64'd0);
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);

        // Layer too large for either unit.
        ovr_en   = 1'b1;
        ovr_cost = 32'h200;
        start_sched({32'h0, 32'h80}, {8'd0, 8'd1}, 32'h100, 32'h1FF);
        take("t3_err", 1'b0, 32'h80, 32'h200, 1'b0, 1'b1, 1'b1, 3);
        ovr_en = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset in the middle of dispatch, then a fresh schedule.
        start_sched({32'h40, 32'h10}, {8'd2, 8'd3}, 32'h60, 32'hFF);
        take("t4_e0", 1'b0, 32'h10, 32'h10, 1'b1, 1'b0, 1'b0, 0);
        rst_i = 1'b1;
        #1;
        chk("t4_rst_outs", 64'(any_out()), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        r0 = req_cnt;
        d0 = done_cnt;
        repeat (5) @(negedge clk_i);
        chk("t4_quiet",
            64'({req_cnt - r0, done_cnt - d0, 31'(dispatch_valid_o)}),
            64'd0);
        d0 = done_cnt;
        start_sched({32'h30, 32'h20}, {8'd1, 8'd1}, 32'hFF, 32'hFF);
        take("t4_n0", 1'b0, 32'h20, 32'h20, 1'b1, 1'b0, 1'b0, 0);
        take("t4_n1", 1'b1, 32'h30, 32'h30, 1'b1, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk_i);
        chk("t4_done_once", 64'(done_cnt - d0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
